// File: rtl/aes444_pkg.sv
// Shared types and constants for the AES444 core arbiter.
package aes444_pkg;

    localparam int unsigned AES444_BLK_W     = 64;
    localparam int unsigned AES444_CORE_LAT  = 11;
    localparam int unsigned AES444_N_REQ_MIN = 2;
    localparam int unsigned AES444_N_REQ_MAX = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        RESP = 2'd3
    } aes444_state_e;

    typedef struct packed {
        logic [AES444_BLK_W-1:0] key;
        logic [AES444_BLK_W-1:0] text;
    } aes444_job_t;

endpackage

// File: rtl/aes444_rr_arb.sv
// Combinational round-robin picker: first requester at or after ptr, circularly.
module aes444_rr_arb
    import aes444_pkg::*;
#(
    parameter int unsigned N_REQ = 4
) (
    input  logic [N_REQ-1:0]         req,
    input  logic [$clog2(N_REQ)-1:0] ptr,
    output logic [N_REQ-1:0]         grant_c,
    output logic [$clog2(N_REQ)-1:0] grant_idx_c,
    output logic                     any_valid_c
);

    localparam int unsigned IDX_W = $clog2(N_REQ);

    int unsigned idx;
    logic        found;

    always_comb begin
        grant_c     = '0;
        grant_idx_c = '0;
        any_valid_c = |req;
        found       = 1'b0;
        idx         = 0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            idx = (32'(ptr) + k) % N_REQ;
            if (!found && req[IDX_W'(idx)]) begin
                found                 = 1'b1;
                grant_c[IDX_W'(idx)]  = 1'b1;
                grant_idx_c           = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/aes444_arbiter.sv
// Round-robin sharing of one AES444 core among N_REQ valid/ready requesters.
// Optional AES444_KEY_REUSE_EN skips the key-load cycle when the key is unchanged.
module aes444_arbiter
    import aes444_pkg::*;
#(
    parameter int unsigned N_REQ    = 4,
    parameter int unsigned CORE_LAT = AES444_CORE_LAT
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_REQ-1:0]              req_valid,
    output logic [N_REQ-1:0]              req_ready,
    input  logic [AES444_BLK_W*N_REQ-1:0] req_key,
    input  logic [AES444_BLK_W*N_REQ-1:0] req_text,
    output logic [N_REQ-1:0]              rsp_valid,
    input  logic [N_REQ-1:0]              rsp_ready,
    output logic [AES444_BLK_W-1:0]       rsp_data,
    output logic                          core_start,
    output logic [AES444_BLK_W-1:0]       core_key,
    output logic [AES444_BLK_W-1:0]       core_text,
    input  logic [AES444_BLK_W-1:0]       core_text_out,
    output logic                          busy
);

    localparam int unsigned W     = AES444_BLK_W;
    localparam int unsigned IDX_W = $clog2(N_REQ);
    localparam int unsigned CNT_W = $clog2(CORE_LAT);

    aes444_state_e    state, state_d;
    logic [IDX_W-1:0] rr_ptr, rr_d;
    logic [IDX_W-1:0] grant_idx, grant_idx_d;
    logic [CNT_W-1:0] lat_cnt, cnt_d;
    logic [W-1:0]     key_d, text_d, data_d;
    logic [N_REQ-1:0] rsp_valid_d;
    logic             start_d, busy_d;

    logic [N_REQ-1:0] pick_oh;
    logic [IDX_W-1:0] pick_idx;
    logic             any_valid;
    aes444_job_t      job_arr [N_REQ];

`ifdef AES444_KEY_REUSE_EN
    logic         key_valid, key_valid_d;
    logic [W-1:0] last_key, last_key_d;
`endif

    for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
        assign job_arr[i].key  = req_key[i*W +: W];
        assign job_arr[i].text = req_text[i*W +: W];
    end

    aes444_rr_arb #(.N_REQ(N_REQ)) u_rr_arb (
        .req         (req_valid),
        .ptr         (rr_ptr),
        .grant_c     (pick_oh),
        .grant_idx_c (pick_idx),
        .any_valid_c (any_valid)
    );

    // Next-state and next-register values; req_ready is the only combinational output.
    always_comb begin
        state_d     = state;
        rr_d        = rr_ptr;
        grant_idx_d = grant_idx;
        cnt_d       = lat_cnt;
        key_d       = core_key;
        text_d      = core_text;
        data_d      = rsp_data;
        rsp_valid_d = rsp_valid;
        start_d     = 1'b0;
        req_ready   = '0;
`ifdef AES444_KEY_REUSE_EN
        key_valid_d = key_valid;
        last_key_d  = last_key;
`endif
        case (state)
            IDLE: begin
                if (any_valid) begin
                    req_ready   = pick_oh;
                    grant_idx_d = pick_idx;
                    key_d       = job_arr[pick_idx].key;
                    text_d      = job_arr[pick_idx].text;
`ifdef AES444_KEY_REUSE_EN
                    // Core reloads key_in while idle, so a matching key is already resident.
                    if (key_valid && (job_arr[pick_idx].key == last_key)) begin
                        state_d = RUN;
                        start_d = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        state_d = LOAD;
                    end
`else
                    state_d = LOAD;
`endif
                end
            end
            LOAD: begin
                state_d = RUN;
                start_d = 1'b1;
                cnt_d   = '0;
`ifdef AES444_KEY_REUSE_EN
                key_valid_d = 1'b1;
                last_key_d  = core_key;
`endif
            end
            RUN: begin
                cnt_d = lat_cnt + CNT_W'(1);
                if (lat_cnt == CNT_W'(CORE_LAT - 1)) begin
                    data_d      = core_text_out;
                    rsp_valid_d = N_REQ'(1) << grant_idx;
                    state_d     = RESP;
                end
            end
            RESP: begin
                if (rsp_ready[grant_idx]) begin
                    rsp_valid_d = '0;
                    state_d     = IDLE;
                    if (32'(grant_idx) == N_REQ - 1) begin
                        rr_d = '0;
                    end else begin
                        rr_d = grant_idx + IDX_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            grant_idx  <= '0;
            lat_cnt    <= '0;
            core_key   <= '0;
            core_text  <= '0;
            rsp_data   <= '0;
            rsp_valid  <= '0;
            core_start <= 1'b0;
            busy       <= 1'b0;
`ifdef AES444_KEY_REUSE_EN
            key_valid  <= 1'b0;
            last_key   <= '0;
`endif
        end else begin
            state      <= state_d;
            rr_ptr     <= rr_d;
            grant_idx  <= grant_idx_d;
            lat_cnt    <= cnt_d;
            core_key   <= key_d;
            core_text  <= text_d;
            rsp_data   <= data_d;
            rsp_valid  <= rsp_valid_d;
            core_start <= start_d;
            busy       <= busy_d;
`ifdef AES444_KEY_REUSE_EN
            key_valid  <= key_valid_d;
            last_key   <= last_key_d;
`endif
        end
    end

endmodule

// File: tb/tb_aes444_arbiter.sv
// Randomized bench for aes444_arbiter: behavioural core model plus a
// job-level scoreboard predicting grants, timing and ciphertext every cycle.
module tb_aes444_arbiter;
    import aes444_pkg::*;

    localparam int N   = 4;
    localparam int W   = 64;
    localparam int LAT = AES444_CORE_LAT;

    logic           clk, rst;
    logic [N-1:0]   req_valid, req_ready, rsp_valid, rsp_ready;
    logic [W*N-1:0] req_key, req_text;
    logic [W-1:0]   rsp_data, core_key, core_text, core_text_out;
    logic           core_start, busy;

    aes444_arbiter #(.N_REQ(N), .CORE_LAT(LAT)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_key       (req_key),
        .req_text      (req_text),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_data      (rsp_data),
        .core_start    (core_start),
        .core_key      (core_key),
        .core_text     (core_text),
        .core_text_out (core_text_out),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Stand-in for the AES444 transform; the arbiter only moves its result.
    function automatic logic [63:0] ref_cipher(input logic [63:0] k, input logic [63:0] p);
        logic [63:0] x, rk;
        x = p;
        for (int r = 0; r < 10; r++) begin
            rk = (k << r) | (k >> (64 - r));
            x  = x ^ rk;
            x  = {x[50:0], x[63:51]} + (64'h9E3779B97F4A7C15 * 64'(r + 1));
        end
        return x;
    endfunction

    // Core model: key register follows key_in while idle, result valid only in
    // the single cycle CORE_LAT-1 after start; garbage otherwise.
    logic [63:0] c_key, c_ct;
    int          c_lat;
    always @(posedge clk) begin
        if (rst) begin
            c_lat         <= 0;
            c_key         <= '0;
            core_text_out <= {$urandom, $urandom};
        end else if (core_start) begin
            c_lat         <= 1;
            c_ct          <= ref_cipher(c_key, core_text);
            core_text_out <= {$urandom, $urandom};
        end else if (c_lat != 0) begin
            if (c_lat == LAT - 2) begin
                core_text_out <= c_ct;
                c_lat         <= 0;
            end else begin
                core_text_out <= {$urandom, $urandom};
                c_lat         <= c_lat + 1;
            end
        end else begin
            c_key         <= core_key;
            core_text_out <= {$urandom, $urandom};
        end
    end

    // Job-level reference model.
    int          cyc = 0;
    bit          in_flight = 0, post_rst = 0, kv = 0;
    int          rr = 0, g = 0, start_cyc = 0, rsp_cyc = 0;
    logic [63:0] jkey, jtext, lk, mkey, mtext;
    bit [N-1:0]  granted = '0;

    always @(negedge clk) begin
        logic [N-1:0] exp_ready, exp_rv;
        int  pick, idx;
        bit  reuse;
        cyc++;
        if (rst) begin
            in_flight = 0; rr = 0; kv = 0; lk = '0;
            mkey = '0; mtext = '0; post_rst = 1;
        end else begin
            exp_ready = '0;
            pick = -1;
            if (!in_flight) begin
                for (int k = 0; k < N; k++) begin
                    idx = (rr + k) % N;
                    if (pick < 0 && req_valid[idx]) pick = idx;
                end
                if (pick >= 0) exp_ready[pick] = 1'b1;
            end
            exp_rv = (in_flight && cyc >= rsp_cyc) ? (N'(1) << g) : '0;

            check("req_ready", 64'(req_ready), 64'(exp_ready));
            check("busy", 64'(busy), 64'(in_flight));
            check("core_start", 64'(core_start), 64'(in_flight && cyc == start_cyc));
            check("rsp_valid", 64'(rsp_valid), 64'(exp_rv));
            if (exp_rv != 0) check("rsp_data", rsp_data, ref_cipher(jkey, jtext));
            check("core_key", core_key, mkey);
            check("core_text", core_text, mtext);
            if (post_rst) check("rsp_data_rst", rsp_data, 64'd0);
            post_rst = 0;

            if (in_flight && cyc >= rsp_cyc && rsp_ready[g]) begin
                in_flight = 0;
                rr = (g + 1) % N;
            end else if (pick >= 0) begin
                g     = pick;
                jkey  = req_key[pick*W +: W];
                jtext = req_text[pick*W +: W];
                mkey  = jkey;
                mtext = jtext;
`ifdef AES444_KEY_REUSE_EN
                reuse = kv && (jkey == lk);
`else
                reuse = 0;
`endif
                kv = 1; lk = jkey;
                start_cyc = cyc + (reuse ? 1 : 2);
                rsp_cyc   = start_cyc + LAT;
                in_flight = 1;
                granted[pick] = 1'b1;
            end
        end
    end

    // Stimulus: a small key pool makes back-to-back equal keys common.
    logic [63:0] kpool0 = 64'h0123_4567_89AB_CDEF;
    logic [63:0] kpool1 = 64'hFEDC_BA98_7654_3210;

    task automatic new_job(input int i);
        int sel;
        sel = int'($urandom_range(2));
        req_valid[i] = 1'b1;
        req_key[i*W +: W]  = (sel == 0) ? kpool0 : (sel == 1) ? kpool1 : {$urandom, $urandom};
        req_text[i*W +: W] = {$urandom, $urandom};
    endtask

    task automatic run(input int cycles, input int p_new, input int p_rdy, input int p_drop);
        repeat (cycles) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (granted[i]) begin
                    granted[i]   = 1'b0;
                    req_valid[i] = 1'b0;
                    if (int'($urandom_range(99)) < p_new) new_job(i);
                end else if (!req_valid[i]) begin
                    if (int'($urandom_range(99)) < p_new) new_job(i);
                end else if (int'($urandom_range(99)) < p_drop) begin
                    req_valid[i] = 1'b0;
                end
                rsp_ready[i] = (int'($urandom_range(99)) < p_rdy);
            end
        end
    endtask

    initial begin
        int i;
        rst = 1'b1; req_valid = '0; rsp_ready = '0; req_key = '0; req_text = '0;
        repeat (3) @(posedge clk);
        #1;
        // All requesters valid out of reset, responses always accepted.
        for (int r = 0; r < N; r++) new_job(r);
        rsp_ready = '1;
        rst = 1'b0;
        run(120, 100, 100, 0);

        // Random traffic with random backpressure and early withdrawals.
        run(1500, 30, 60, 2);

        // Long backpressure with all requesters pending.
        i = 0;
        while (i < 300 && rsp_valid == '0) begin
            run(1, 100, 0, 0);
            i++;
        end
        check("bp_rsp_seen", 64'(rsp_valid != '0), 64'd1);
        run(20, 100, 0, 0);
        run(100, 100, 100, 0);

        // Reset in the middle of a job, then resume.
        i = 0;
        while (i < 300 && !core_start) begin
            run(1, 50, 100, 0);
            i++;
        end
        check("start_seen", 64'(core_start), 64'd1);
        run(4, 50, 100, 0);
        rst = 1'b1;
        run(1, 50, 100, 0);
        rst = 1'b0;
        run(300, 50, 100, 0);

        run(500, 40, 50, 3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/aes444_arbiter.md
Name: aes444_arbiter

Overview:
- Shares one AES444 small-scale encryption core (64-bit key, 64-bit block, 10 rounds) among N_REQ requesters.
- Each requester uses a valid/ready request channel and a valid/ready response channel.
- The block selects a requester by round-robin, stages key and plaintext into the core, pulses start, and counts core latency.
- It returns the ciphertext to the granted requester and holds it until accepted. It sits between client logic and the core instance.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- CORE_LAT, 11, cycles from the core start cycle until text_out holds the ciphertext

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  N_REQ  per-requester request valid
- req_ready  out  N_REQ  per-requester request accepted (one-hot or zero)
- req_key  in  64*N_REQ  key, requester i at [64i+63:64i]
- req_text  in  64*N_REQ  plaintext, same packing
- rsp_valid  out  N_REQ  per-requester response valid (one-hot or zero)
- rsp_ready  in  N_REQ  per-requester response accept
- rsp_data  out  64  ciphertext, shared bus, qualified by rsp_valid
- core_start  out  1  start pulse to core
- core_key  out  64  core key_in
- core_text  out  64  core text_in
- core_text_out  in  64  core text_out
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (rst=1 at clk edge) forces the following:
  - state IDLE; rr pointer 0; grant register 0
  - req_ready=0, rsp_valid=0, core_start=0, busy=0
  - core_key=0, core_text=0, rsp_data=0
- The core shares rst. Reset mid-operation aborts the job with no response. Requesters must re-issue.
- States: IDLE, LOAD, RUN, RESP.
- IDLE:
  - If any req_valid is high, pick the first requester at or after the rr pointer in circular order.
  - Assert req_ready[g] combinationally that same cycle.
  - At the edge, capture req_key[g] into core_key and req_text[g] into core_text, store g, and go to LOAD.
  - req_ready is only ever asserted in IDLE.
- LOAD:
  - Exactly one cycle, core_start=0.
  - Lets the idle core absorb core_key into its key register. The core requires the key stable one cycle before start.
  - Next state is RUN.
- RUN:
  - First cycle: core_start=1 for exactly one cycle, and the latency counter is cleared.
  - The counter increments each cycle.
  - When the counter reaches CORE_LAT-1, at that edge capture core_text_out into rsp_data and go to RESP.
  - The ciphertext is therefore registered CORE_LAT cycles after the start cycle.
- RESP:
  - rsp_valid[g]=1 and rsp_data stable.
  - On rsp_ready[g]=1: go to IDLE, set rr pointer to (g+1) mod N_REQ, drop rsp_valid.
  - Backpressure of any length is allowed. The core is idle meanwhile.
- core_key and core_text hold their values from capture until the next grant. They are never changed while in LOAD or RUN.
- Request-to-response minimum: req handshake edge → LOAD (1) → RUN (CORE_LAT) → rsp_valid visible. That is 2+CORE_LAT = 13 cycles after the handshake cycle.
- Requester fairness:
  - A requester dropping req_valid before grant is legal.
  - A requester asserting valid during IDLE in the same cycle as a higher-rr-priority requester waits.
  - Each requester waits at most N_REQ-1 jobs.
- rsp_ready[i] for i≠g is ignored.

Optional Feature:
- Macro: AES444_KEY_REUSE_EN.
- Defined:
  - Store the last loaded key and a key_valid flag. key_valid is cleared by rst and set after the first LOAD.
  - If key_valid is set and the granted key equals the stored key, skip LOAD and go IDLE→RUN directly. The core key register already holds that key, because the core reloads key_in every idle cycle.
  - Minimum latency becomes 1+CORE_LAT = 12 cycles.
- Undefined: LOAD is always taken.

Decomposition:
- Shared package aes444_pkg holds:
  - state enum (IDLE, LOAD, RUN, RESP)
  - AES444_BLK_W = 64
  - AES444_CORE_LAT = 11
  - N_REQ limit constants
- Natural sub-module: aes444_rr_arb, a combinational round-robin picker. Inputs are the request vector and pointer. Outputs are one-hot grant, grant index, and any-valid.

Test Plan:
- Single request: rst, then req_valid[0]=1 with key K and text P.
  - req_ready[0] is high that cycle; core_start pulses at handshake+2.
  - rsp_valid[0] rises at handshake+13.
  - rsp_data equals the golden-model AES444(K,P).
- All four requesters valid simultaneously from reset:
  - grants occur in order 0,1,2,3 with rsp_ready tied high;
  - exactly one core_start per job; no overlap.
- Backpressure: hold rsp_ready[1]=0 for 20 cycles.
  - rsp_valid[1] and rsp_data stay stable; no req_ready is asserted.
  - After acceptance, the next grant goes to requester 2.
- Reset mid-RUN: assert rst 5 cycles after core_start.
  - Next cycle all outputs are 0 and state is IDLE; no rsp_valid follows.
  - A new request completes correctly.
- With AES444_KEY_REUSE_EN: two back-to-back jobs with the same key.
  - The second job's core_start comes at handshake+1, rsp_valid at handshake+12, and the ciphertext is correct.
  - A different key restores the 13-cycle path.
- rr wrap: after a grant to requester 3 with requesters 0 and 3 valid, the next grant goes to requester 0.
